// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative HI/LO multiply/divide unit, fixed 33-cycle latency.
// Divide datapath present only when MULDIV_DIV_EN is defined.
module muldiv_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] busa,
    input  logic [31:0] busb,
    input  logic        hi_we,
    input  logic        lo_we,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;

    state_t      state, state_next;
    logic [4:0]  cnt;
    logic [31:0] a_r, p_hi, p_lo;
    logic        neg_q;
    logic        accept;
    logic        sa, sb;
    logic [31:0] abs_a, abs_b;
    logic [32:0] add_sum;
    logic [63:0] prod_abs, prod_fix;

`ifdef MULDIV_DIV_EN
    logic        is_div, dz, neg_r;
    logic [32:0] shifted, diff;
    assign accept  = start && (state == IDLE);
    assign shifted = {p_hi, p_lo[31]};
    assign diff    = shifted - {1'b0, a_r};
`else
    assign accept = start && (state == IDLE) && !op[1];
`endif

    // op[0]=0 selects the signed flavour for both multiply and divide
    assign sa       = ~op[0] & busa[31];
    assign sb       = ~op[0] & busb[31];
    assign abs_a    = sa ? (32'd0 - busa) : busa;
    assign abs_b    = sb ? (32'd0 - busb) : busb;
    assign add_sum  = {1'b0, p_hi} + (p_lo[0] ? {1'b0, a_r} : 33'd0);
    assign prod_abs = {p_hi, p_lo};
    assign prod_fix = neg_q ? (64'd0 - prod_abs) : prod_abs;
    assign busy     = (state != IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = RUN;
            RUN:     if (cnt == 5'd31) state_next = FINISH;
            FINISH:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt   <= 5'd0;
            a_r   <= 32'd0;
            p_hi  <= 32'd0;
            p_lo  <= 32'd0;
            neg_q <= 1'b0;
            hi    <= 32'd0;
            lo    <= 32'd0;
            done  <= 1'b0;
`ifdef MULDIV_DIV_EN
            is_div <= 1'b0;
            dz     <= 1'b0;
            neg_r  <= 1'b0;
`endif
        end else begin
            done <= (state == FINISH);
            case (state)
                IDLE: begin
                    if (hi_we) hi <= wdata;
                    if (lo_we) lo <= wdata;
                    if (accept) begin
                        // Multiplier / dividend in p_lo, multiplicand / divisor in a_r
                        cnt   <= 5'd0;
                        a_r   <= abs_b;
                        p_hi  <= 32'd0;
                        p_lo  <= abs_a;
                        neg_q <= sa ^ sb;
`ifdef MULDIV_DIV_EN
                        is_div <= op[1];
                        dz     <= (busb == 32'd0);
                        neg_r  <= sa;
`endif
                    end
                end
                RUN: begin
                    cnt <= cnt + 5'd1;
`ifdef MULDIV_DIV_EN
                    if (is_div) begin
                        // Restoring step: diff[32] set means the trial subtract borrowed
                        p_hi <= diff[32] ? shifted[31:0] : diff[31:0];
                        p_lo <= {p_lo[30:0], ~diff[32]};
                    end else
`endif
                    begin
                        p_hi <= add_sum[32:1];
                        p_lo <= {add_sum[0], p_lo[31:1]};
                    end
                end
                FINISH: begin
`ifdef MULDIV_DIV_EN
                    if (is_div) begin
                        hi <= neg_r ? (32'd0 - p_hi) : p_hi;
                        lo <= dz ? 32'hFFFF_FFFF : (neg_q ? (32'd0 - p_lo) : p_lo);
                    end else
`endif
                    begin
                        hi <= prod_fix[63:32];
                        lo <= prod_fix[31:0];
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - directed vector bench for muldiv_unit.
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] busa = 32'd0, busb = 32'd0;
    logic        hi_we = 1'b0, lo_we = 1'b0;
    logic [31:0] wdata = 32'd0;
    logic        busy, done;
    logic [31:0] hi, lo;

    int errors = 0;
    int checks = 0;

    muldiv_unit dut (
        .clk(clk), .reset(reset), .start(start), .op(op),
        .busa(busa), .busb(busb), .hi_we(hi_we), .lo_we(lo_we),
        .wdata(wdata), .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] ehi;
        logic [31:0] elo;
    } vec_t;

    vec_t vecs[13];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Starts an op at the next edge (E0) and waits for done; lat = edges after E0.
    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          output int lat, output logic held, output logic busy_seen);
        logic [31:0] h0, l0;
        h0 = hi; l0 = lo; held = 1'b1; lat = 0; busy_seen = 1'b0;
        @(negedge clk); start = 1'b1; op = o; busa = a; busb = b;
        @(posedge clk); #1 start = 1'b0;
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk); #1;
            if (done) begin lat = n; break; end
            if (busy) busy_seen = 1'b1;
            if (hi !== h0 || lo !== l0) held = 1'b0;
        end
    endtask

    int   lat;
    logic held, busy_seen, flag;
    logic [31:0] h0, l0;

    initial begin
        vecs[0]  = '{2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
        vecs[1]  = '{2'b00, 32'hFFFFFFF9, 32'h00000006, 32'hFFFFFFFF, 32'hFFFFFFD6};
        vecs[2]  = '{2'b01, 32'h12345678, 32'h00000009, 32'h00000000, 32'hA3D70A38};
        vecs[3]  = '{2'b00, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
        vecs[4]  = '{2'b00, 32'h80000000, 32'h00000001, 32'hFFFFFFFF, 32'h80000000};
        vecs[5]  = '{2'b01, 32'h80000000, 32'h00000002, 32'h00000001, 32'h00000000};
        vecs[6]  = '{2'b00, 32'h00000000, 32'hFFFFFFFF, 32'h00000000, 32'h00000000};
        vecs[7]  = '{2'b10, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD};
        vecs[8]  = '{2'b11, 32'h00000064, 32'h00000000, 32'h00000064, 32'hFFFFFFFF};
        vecs[9]  = '{2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
        vecs[10] = '{2'b11, 32'h00000064, 32'h00000007, 32'h00000002, 32'h0000000E};
        vecs[11] = '{2'b10, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};
        vecs[12] = '{2'b10, 32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFF9, 32'hFFFFFFFF};

        #12;
        chk("reset_busy", {63'd0, busy}, 64'd0);
        chk("reset_done", {63'd0, done}, 64'd0);
        chk("reset_hi", {32'd0, hi}, 64'd0);
        chk("reset_lo", {32'd0, lo}, 64'd0);
        @(negedge clk); reset = 1'b0;

        // MTHI / MTLO while idle
        @(negedge clk); hi_we = 1'b1; wdata = 32'hAAAA5555;
        @(negedge clk); hi_we = 1'b0; lo_we = 1'b1; wdata = 32'h1234ABCD;
        @(negedge clk); lo_we = 1'b0;
        chk("mthi", {32'd0, hi}, {32'd0, 32'hAAAA5555});
        chk("mtlo", {32'd0, lo}, {32'd0, 32'h1234ABCD});

        for (int i = 0; i < 13; i++) begin
`ifndef MULDIV_DIV_EN
            if (vecs[i].op[1]) begin
                h0 = hi; l0 = lo; flag = 1'b0;
                @(negedge clk); start = 1'b1; op = vecs[i].op; busa = vecs[i].a; busb = vecs[i].b;
                @(posedge clk); #1 start = 1'b0;
                for (int n = 0; n < 40; n++) begin
                    @(posedge clk); #1;
                    if (busy || done) flag = 1'b1;
                end
                chk($sformatf("v%0d_div_ignored", i), {63'd0, flag}, 64'd0);
                chk($sformatf("v%0d_hilo_kept", i), {hi, lo}, {h0, l0});
                continue;
            end
`endif
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, lat, held, busy_seen);
            chk($sformatf("v%0d_latency", i), 64'(lat), 64'd33);
            chk($sformatf("v%0d_hi", i), {32'd0, hi}, {32'd0, vecs[i].ehi});
            chk($sformatf("v%0d_lo", i), {32'd0, lo}, {32'd0, vecs[i].elo});
            chk($sformatf("v%0d_hold", i), {62'd0, held, busy_seen}, 64'd3);
            chk($sformatf("v%0d_busy_at_done", i), {63'd0, busy}, 64'd0);
            @(posedge clk); #1;
            chk($sformatf("v%0d_done_one_cycle", i), {63'd0, done}, 64'd0);
        end

        // start + hi_we during a running MULT are both dropped
        @(negedge clk); start = 1'b1; op = 2'b00; busa = 32'd3; busb = 32'd5;
        @(posedge clk); #1 start = 1'b0;
        lat = 0;
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk); #1;
            if (done) begin lat = n; break; end
            if (n == 9) begin
                start = 1'b1; op = 2'b01; busa = 32'd100; busb = 32'd100;
                hi_we = 1'b1; wdata = 32'hDEADBEEF;
            end
            if (n == 10) begin start = 1'b0; hi_we = 1'b0; end
        end
        chk("busy_ignore_latency", 64'(lat), 64'd33);
        chk("busy_ignore_result", {hi, lo}, {32'd0, 32'd15});

        // Write coinciding with an accepted start lands, then FINISH overwrites it
        @(negedge clk); start = 1'b1; op = 2'b01; busa = 32'd2; busb = 32'd3;
        hi_we = 1'b1; lo_we = 1'b1; wdata = 32'h12345678;
        @(posedge clk); #1 start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
        chk("start_write_lands", {hi, lo}, {32'h12345678, 32'h12345678});
        lat = 0;
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk); #1;
            if (done) begin lat = n; break; end
        end
        chk("start_write_latency", 64'(lat), 64'd33);
        chk("start_write_overwritten", {hi, lo}, {32'd0, 32'd6});

        // Reset between edges mid-RUN, then start on the first edge after release
        @(negedge clk); start = 1'b1; op = 2'b00; busa = 32'hFFFFFFF9; busb = 32'd6;
        @(posedge clk); #1 start = 1'b0;
        repeat (5) @(posedge clk);
        #3 reset = 1'b1;
        #1;
        chk("midrun_reset_busy", {63'd0, busy}, 64'd0);
        chk("midrun_reset_hilo", {hi, lo}, 64'd0);
        flag = 1'b0;
        repeat (3) begin @(posedge clk); #1; if (done) flag = 1'b1; end
        @(negedge clk); reset = 1'b0; start = 1'b1; op = 2'b01; busa = 32'd7; busb = 32'd6;
        @(posedge clk); #1 start = 1'b0;
        lat = 0;
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk); #1;
            if (done) begin lat = n; break; end
        end
        chk("midrun_reset_no_done", {63'd0, flag}, 64'd0);
        chk("after_reset_latency", 64'(lat), 64'd33);
        chk("after_reset_result", {hi, lo}, {32'd0, 32'd42});

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
